// File: rtl/m_ingress_arb_if.sv
// Signal bundle for m_ingress_arb: per-channel ingress streams, merged egress stream, error flags.
// master drives the ingress side and the egress ready; slave is the arbiter itself.
interface m_ingress_arb_if #(
  parameter int unsigned N_CH   = 4,
  parameter int unsigned DATA_W = 128,
  parameter int unsigned LEN_W  = 16,
  parameter int unsigned BUF_W  = $clog2(N_CH)
);
  logic [N_CH-1:0]        in_vld_w;
  logic [N_CH-1:0]        in_rdy_r;
  logic [N_CH-1:0]        in_sop_w;
  logic [N_CH-1:0]        in_eop_w;
  logic [N_CH*LEN_W-1:0]  in_length_w;
  logic [N_CH*DATA_W-1:0] in_data_w;
  logic                   out_vld_r;
  logic                   out_rdy_w;
  logic                   out_sop_r;
  logic                   out_eop_r;
  logic [LEN_W-1:0]       out_length_r;
  logic [DATA_W-1:0]      out_data_r;
  logic [BUF_W-1:0]       out_buffer_r;
  logic [N_CH-1:0]        err_r;

  modport master (
    output in_vld_w, in_sop_w, in_eop_w, in_length_w, in_data_w, out_rdy_w,
    input  in_rdy_r, out_vld_r, out_sop_r, out_eop_r, out_length_r, out_data_r,
           out_buffer_r, err_r
  );

  modport slave (
    input  in_vld_w, in_sop_w, in_eop_w, in_length_w, in_data_w, out_rdy_w,
    output in_rdy_r, out_vld_r, out_sop_r, out_eop_r, out_length_r, out_data_r,
           out_buffer_r, err_r
  );
endinterface

// File: rtl/m_ingress_arb.sv
// Multi-channel packet ingress: per-channel framing check and FIFO, packet-granular
// round-robin arbitration into one registered output stream tagged with its source channel.
module m_ingress_arb #(
  parameter int unsigned N_CH       = 4,
  parameter int unsigned DATA_W     = 128,
  parameter int unsigned LEN_W      = 16,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned BUF_W      = $clog2(N_CH)
) (
  input  logic           clk,
  input  logic           rst,
  m_ingress_arb_if.slave bus
);
  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned ENT_W = 2 + LEN_W + DATA_W;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);
  localparam logic [BUF_W-1:0] LAST_CH  = BUF_W'(N_CH - 1);

  typedef enum logic [0:0] {StIdle, StLocked} state_e;

  // Channel FIFOs, entry layout {sop, eop, length, data}
  logic [ENT_W-1:0] mem_q    [N_CH][FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q [N_CH];
  logic [PTR_W-1:0] rd_ptr_q [N_CH];
  logic [CNT_W-1:0] cnt_q    [N_CH];
  logic [ENT_W-1:0] wr_ent   [N_CH];

  logic [N_CH-1:0] in_pkt_q, in_pkt_d;
  logic [N_CH-1:0] err_q, err_d;
  logic [N_CH-1:0] rdy, wr_en, pop, nonempty;

  state_e           state_q, state_d;
  logic [BUF_W-1:0] lock_ch_q, lock_ch_d;
  logic [BUF_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [BUF_W-1:0] sel, cand;
  logic             found, fire;
  logic [ENT_W-1:0] head;
  logic             head_eop;
  int               idx;

  logic              out_vld_q, out_sop_q, out_eop_q;
  logic [LEN_W-1:0]  out_len_q;
  logic [DATA_W-1:0] out_data_q;
  logic [BUF_W-1:0]  out_buf_q;

  // Ingress: ready from registered count, framing check decides write vs drop.
  always_comb begin
    in_pkt_d = in_pkt_q;
    err_d    = err_q;
    for (int i = 0; i < N_CH; i++) begin
      rdy[i]      = !rst && (cnt_q[i] != FULL_CNT);
      nonempty[i] = (cnt_q[i] != '0);
      wr_ent[i]   = {bus.in_sop_w[i], bus.in_eop_w[i],
                     bus.in_length_w[i*LEN_W +: LEN_W], bus.in_data_w[i*DATA_W +: DATA_W]};
      wr_en[i]    = 1'b0;
      if (bus.in_vld_w[i] && rdy[i]) begin
        // Legal iff sop appears exactly when outside a packet; any written eop closes it.
        if (bus.in_sop_w[i] != in_pkt_q[i]) begin
          wr_en[i]    = 1'b1;
          in_pkt_d[i] = !bus.in_eop_w[i];
        end else begin
          err_d[i] = 1'b1;
        end
      end
    end
  end

  // Arbiter: pick a channel, issue its head beat, advance lock/RR state.
  always_comb begin
    sel       = lock_ch_q;
    cand      = '0;
    found     = 1'b0;
    idx       = 0;
    state_d   = state_q;
    lock_ch_d = lock_ch_q;
    rr_ptr_d  = rr_ptr_q;
    pop       = '0;

    if (state_q == StIdle) begin
      for (int k = 0; k < N_CH; k++) begin
        idx = int'(rr_ptr_q) + k;
        if (idx >= N_CH) idx = idx - N_CH;
        cand = BUF_W'(idx);
        if (!found && nonempty[cand]) begin
          found = 1'b1;
          sel   = cand;
        end
      end
    end else begin
      found = nonempty[lock_ch_q];
    end

    fire     = found && (!out_vld_q || bus.out_rdy_w);
    head     = mem_q[sel][rd_ptr_q[sel]];
    head_eop = head[ENT_W-2];

    if (fire) begin
      pop[sel] = 1'b1;
      if (state_q == StIdle) begin
        rr_ptr_d = (sel == LAST_CH) ? '0 : sel + BUF_W'(1);
        if (!head_eop) begin
          state_d   = StLocked;
          lock_ch_d = sel;
        end
      end else if (head_eop) begin
        state_d = StIdle;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N_CH; i++) begin
        wr_ptr_q[i] <= '0;
        rd_ptr_q[i] <= '0;
        cnt_q[i]    <= '0;
      end
      in_pkt_q <= '0;
      err_q    <= '0;
    end else begin
      in_pkt_q <= in_pkt_d;
      err_q    <= err_d;
      for (int i = 0; i < N_CH; i++) begin
        if (wr_en[i]) wr_ptr_q[i] <= wr_ptr_q[i] + PTR_W'(1);
        if (pop[i])   rd_ptr_q[i] <= rd_ptr_q[i] + PTR_W'(1);
        if (wr_en[i] && !pop[i]) begin
          cnt_q[i] <= cnt_q[i] + CNT_W'(1);
        end else if (!wr_en[i] && pop[i]) begin
          cnt_q[i] <= cnt_q[i] - CNT_W'(1);
        end
      end
    end
  end

  // Storage needs no reset; validity comes from the counts.
  always_ff @(posedge clk) begin
    for (int i = 0; i < N_CH; i++) begin
      if (wr_en[i]) mem_q[i][wr_ptr_q[i]] <= wr_ent[i];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      lock_ch_q  <= '0;
      rr_ptr_q   <= '0;
      out_vld_q  <= 1'b0;
      out_sop_q  <= 1'b0;
      out_eop_q  <= 1'b0;
      out_len_q  <= '0;
      out_data_q <= '0;
      out_buf_q  <= '0;
    end else begin
      state_q   <= state_d;
      lock_ch_q <= lock_ch_d;
      rr_ptr_q  <= rr_ptr_d;
      if (fire) begin
        out_vld_q  <= 1'b1;
        out_sop_q  <= head[ENT_W-1];
        out_eop_q  <= head_eop;
        out_len_q  <= head[DATA_W +: LEN_W];
        out_data_q <= head[DATA_W-1:0];
        out_buf_q  <= sel;
      end else if (bus.out_rdy_w) begin
        out_vld_q <= 1'b0;
      end
    end
  end

  assign bus.in_rdy_r     = rdy;
  assign bus.err_r        = err_q;
  assign bus.out_vld_r    = out_vld_q;
  assign bus.out_sop_r    = out_sop_q;
  assign bus.out_eop_r    = out_eop_q;
  assign bus.out_length_r = out_len_q;
  assign bus.out_data_r   = out_data_q;
  assign bus.out_buffer_r = out_buf_q;

endmodule
